// File: rtl/serial_to_parallel.sv
// Serial-to-parallel deserialiser: accepts one bit per qualified clock and
// presents each completed DATA_WIDTH-bit word with a one-cycle ready pulse.
module serial_to_parallel #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  data_valid,
    input  logic                  serial_data,
    output logic                  data_ready_out,
    output logic [DATA_WIDTH-1:0] parallel_data
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [DATA_WIDTH-1:0] sreg_q,  sreg_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] sreg_shift;

    // Shift direction decides whether the first bit ends up in the MSB or the LSB.
    always_comb begin
        sreg_shift = sreg_q;
        if (MSB_FIRST) begin
            sreg_shift = {sreg_q[DATA_WIDTH-2:0], serial_data};
        end else begin
            sreg_shift = {serial_data, sreg_q[DATA_WIDTH-1:1]};
        end
    end

    // Next-state: gaps hold everything; the last bit publishes the word that
    // includes it and restarts the count so the next word follows with no dead cycle.
    always_comb begin
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        pdata_d = pdata_q;
        ready_d = 1'b0;
        if (data_valid) begin
            sreg_d = sreg_shift;
            if (cnt_q == LAST_BIT) begin
                cnt_d   = '0;
                pdata_d = sreg_shift;
                ready_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers; reset discards any partial word and clears the output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            sreg_q  <= '0;
            pdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            pdata_q <= pdata_d;
            ready_q <= ready_d;
        end
    end

    assign data_ready_out = ready_q;
    assign parallel_data  = pdata_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel: an MSB-first and an LSB-first instance
// share one input stream and are compared every cycle against a shift model
// plus hand-computed word values.
module tb_serial_to_parallel;

    logic       clk;
    logic       rstn;
    logic       data_valid;
    logic       serial_data;
    logic       rdy_m, rdy_l;
    logic [7:0] pd_m, pd_l;

    serial_to_parallel #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rstn(rstn), .data_valid(data_valid), .serial_data(serial_data),
        .data_ready_out(rdy_m), .parallel_data(pd_m)
    );

    serial_to_parallel #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rstn(rstn), .data_valid(data_valid), .serial_data(serial_data),
        .data_ready_out(rdy_l), .parallel_data(pd_l)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // reference model
    logic [7:0] m_sm, m_sl, e_pm, e_pl;
    logic       e_rdy;
    int         m_cnt;
    int         cyc = 0;
    int         pulses = 0;
    int         last_pulse = 0;
    int         pulse_gap = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_sm = 8'h00; m_sl = 8'h00; e_pm = 8'h00; e_pl = 8'h00;
        e_rdy = 1'b0; m_cnt = 0;
    endtask

    // One clock: drive at negedge, sample 1 ns after the rising edge.
    task automatic step(input logic v, input logic b);
        @(negedge clk);
        data_valid  = v;
        serial_data = v ? b : 1'bx;
        @(posedge clk);
        #1;
        cyc++;
        e_rdy = 1'b0;
        if (v) begin
            m_sm = {m_sm[6:0], b};
            m_sl = {b, m_sl[7:1]};
            if (m_cnt == 7) begin
                m_cnt = 0;
                e_pm  = m_sm;
                e_pl  = m_sl;
                e_rdy = 1'b1;
            end else begin
                m_cnt++;
            end
        end
        check("rdy_msb", 32'(rdy_m), 32'(e_rdy));
        check("rdy_lsb", 32'(rdy_l), 32'(e_rdy));
        check("pd_msb",  32'(pd_m),  32'(e_pm));
        check("pd_lsb",  32'(pd_l),  32'(e_pl));
        if (rdy_m) begin
            pulses++;
            pulse_gap  = cyc - last_pulse;
            last_pulse = cyc;
        end
    endtask

    task automatic send_byte_msb(input logic [7:0] val);
        for (int i = 7; i >= 0; i--) step(1'b1, val[i]);
    endtask

    int p0;

    initial begin
        model_reset();
        rstn        = 1'b0;
        data_valid  = 1'b0;
        serial_data = 1'b0;

        // 1. reset held for 25 cycles
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            check("reset_pd", 32'(pd_m), 32'h00);
            check("reset_rdy", 32'(rdy_m | rdy_l), 32'h0);
        end
        @(negedge clk);
        rstn = 1'b1;
        step(1'b0, 1'b0);

        // 2. single word 1,0,1,0,0,1,0,1
        p0 = pulses;
        send_byte_msb(8'hA5);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("t2_pulses", 32'(pulses - p0), 32'd1);
        check("t2_pd_msb", 32'(pd_m), 32'hA5);
        check("t2_pd_lsb", 32'(pd_l), 32'hA5);

        // 3. back-to-back words, valid held high
        send_byte_msb(8'h3C);
        check("t3_pd_first", 32'(pd_m), 32'h3C);
        check("t3_rdy_first", 32'(rdy_m), 32'h1);
        send_byte_msb(8'hFF);
        check("t3_pd_second", 32'(pd_m), 32'hFF);
        check("t3_gap", 32'(pulse_gap), 32'd8);
        step(1'b0, 1'b0);

        // 4. 8'hC3 as bursts of 5 and 3 bits with a 3-cycle gap
        p0 = pulses;
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b0);
        step(1'b1, 1'b0); step(1'b1, 1'b0);
        step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        check("t4_no_pulse_in_gap", 32'(pulses - p0), 32'd0);
        check("t4_pd_held", 32'(pd_m), 32'hFF);
        step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        check("t4_pulses", 32'(pulses - p0), 32'd1);
        check("t4_pd", 32'(pd_m), 32'hC3);

        // 5. asynchronous reset in the middle of a word
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
        @(negedge clk);
        data_valid = 1'b0;
        #3;
        rstn = 1'b0;
        #2;
        check("t5_async_pd", 32'(pd_m), 32'h00);
        check("t5_async_rdy", 32'(rdy_m), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        check("t5_in_reset_pd", 32'(pd_l), 32'h00);
        @(negedge clk);
        rstn = 1'b1;
        p0 = pulses;
        send_byte_msb(8'h81);
        step(1'b0, 1'b0);
        check("t5_pulses", 32'(pulses - p0), 32'd1);
        check("t5_pd_msb", 32'(pd_m), 32'h81);
        check("t5_pd_lsb", 32'(pd_l), 32'h81);

        // 6. LSB-first word 1,0,0,0,0,0,0,0 then random bits with random gaps
        send_byte_msb(8'h80);
        check("t6_pd_lsb", 32'(pd_l), 32'h01);
        check("t6_pd_msb", 32'(pd_m), 32'h80);
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
        end
        step(1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
